// File: rtl/perf_display_unit_pkg.sv
// Shared channel map constants and size helpers for the perf display unit.
package perf_display_pkg;

    localparam int CH_SYSCALL  = 0;
    localparam int CH_PC       = 1;
    localparam int CH_CNT_BASE = 2;

    // SyscallOut, PC, the counters, then Mdata as the last channel.
    function automatic int num_ch(input int num_cnt);
        return num_cnt + 3;
    endfunction

    function automatic int sel_w(input int nch);
        return $clog2(nch);
    endfunction

endpackage

// File: rtl/perf_display_unit_if.sv
// Board-side bus of the display unit: event strobes, display sources, selectors and outputs.
interface perf_display_if
    import perf_display_pkg::*;
#(
    parameter int NUM_CNT = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12
);
    localparam int SEL_W = sel_w(num_ch(NUM_CNT));

    logic               halt;
    logic [NUM_CNT-1:0] ev;
    logic               clr_cnt;
    logic [DATA_W-1:0]  SyscallOut;
    logic [DATA_W-1:0]  PC;
    logic [DATA_W-1:0]  Mdata;
    logic [SEL_W-1:0]   sel;
    logic               auto_mode;
    logic               freeze;
    logic [ADDR_W-1:0]  in_addr;
    logic [ADDR_W-1:0]  RAM_addr;
    logic [DATA_W-1:0]  chose_out;
    logic [SEL_W-1:0]   disp_idx;
    logic [NUM_CNT-1:0] cnt_ovf;

    modport master (
        output halt, ev, clr_cnt, SyscallOut, PC, Mdata, sel, auto_mode, freeze, in_addr,
        input  RAM_addr, chose_out, disp_idx, cnt_ovf
    );

    modport slave (
        input  halt, ev, clr_cnt, SyscallOut, PC, Mdata, sel, auto_mode, freeze, in_addr,
        output RAM_addr, chose_out, disp_idx, cnt_ovf
    );

endinterface

// File: rtl/perf_display_unit_counter.sv
// Saturating event counter with a sticky overflow flag; clear wins over increment.
module perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] value,
    output logic             ovf
);

    logic [CNT_W-1:0] value_q, value_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        value_d = value_q;
        ovf_d   = ovf_q;
        if (clr) begin
            value_d = '0;
            ovf_d   = 1'b0;
        end else if (inc) begin
            if (&value_q) ovf_d   = 1'b1;
            else          value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value = value_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/perf_display_unit.sv
// Debug display unit: event counters plus a registered channel mux with manual,
// auto-scroll and freeze modes feeding the seven-segment driver.
module perf_display_unit
    import perf_display_pkg::*;
#(
    parameter int NUM_CNT    = 4,
    parameter int CNT_W      = 16,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 12,
    parameter int SCROLL_DIV = 50_000_000
) (
    input logic          clk,
    input logic          reset,
    perf_display_if.slave bus
);

    localparam int NUM_CH = num_ch(NUM_CNT);
    localparam int SEL_W  = sel_w(NUM_CH);
    localparam int TMR_W  = $clog2(SCROLL_DIV);

    logic [NUM_CH-1:0][DATA_W-1:0]  ch;
    logic [NUM_CNT-1:0][CNT_W-1:0]  cnt_val;
    logic [NUM_CNT-1:0]             cnt_ovf;

    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              auto_q, auto_d;
    logic [TMR_W-1:0]  tmr_eff;

    assign ch[CH_SYSCALL] = bus.SyscallOut;
    assign ch[CH_PC]      = bus.PC;
    assign ch[NUM_CH-1]   = bus.Mdata;

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        perf_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (bus.clr_cnt),
            .inc   (bus.ev[i] & ~bus.halt),
            .value (cnt_val[i]),
            .ovf   (cnt_ovf[i])
        );
        assign ch[CH_CNT_BASE+i] = DATA_W'(cnt_val[i]);
    end

    always_comb begin
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        out_d   = out_q;
        auto_d  = auto_q;
        // A fresh entry into auto mode restarts the step from zero, even if
        // the timer was left non-zero by a freeze spanning a mode change.
        tmr_eff = (bus.auto_mode && !auto_q) ? '0 : tmr_q;
        if (!bus.freeze) begin
            auto_d = bus.auto_mode;
            if (!bus.auto_mode) begin
                tmr_d = '0;
                idx_d = (32'(bus.sel) < NUM_CH) ? bus.sel : '0;
            end else if (tmr_eff == TMR_W'(SCROLL_DIV - 1)) begin
                tmr_d = '0;
                idx_d = (idx_q == SEL_W'(NUM_CH - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                tmr_d = tmr_eff + 1'b1;
            end
            out_d = ch[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q  <= '0;
            idx_q  <= '0;
            out_q  <= '0;
            auto_q <= 1'b0;
        end else begin
            tmr_q  <= tmr_d;
            idx_q  <= idx_d;
            out_q  <= out_d;
            auto_q <= auto_d;
        end
    end

    assign bus.RAM_addr  = ADDR_W'(bus.in_addr);
    assign bus.chose_out = out_q;
    assign bus.disp_idx  = idx_q;
    assign bus.cnt_ovf   = cnt_ovf;

endmodule

// File: doc/perf_display_unit.md
# perf_display_unit

Parametrised debug/statistics display unit for the single-cycle MIPS CPU board top. Owns NUM_CNT saturating event counters (cycles, jumps, branches, branches taken, …) and a registered display selector covering SyscallOut, PC, every counter and RAM readout. Adds three modes to the plain display mux: freeze, auto-scroll through channels, and counter clear/overflow flags. Sits between the datapath/control unit and the seven-segment driver.

## Interface
- NUM_CNT, 4, number of event counters (1..13)
- CNT_W, 16, counter width (1..DATA_W)
- DATA_W, 32, display word width
- ADDR_W, 12, RAM probe address width
- SCROLL_DIV, 50_000_000, clk cycles per auto-scroll step (≥2)
- Derived: NUM_CH = NUM_CNT+3; SEL_W = $clog2(NUM_CH)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high; one clock, sync active-high reset, as already decided
- halt  in  1  CPU halted; counting suppressed while 1
- ev  in  NUM_CNT  per-counter increment strobe, one count per cycle high
- clr_cnt  in  1  synchronous clear of all counters and overflow flags
- SyscallOut  in  DATA_W  channel 0
- PC  in  DATA_W  channel 1
- Mdata  in  DATA_W  channel NUM_CH-1 (RAM data at RAM_addr)
- sel  in  SEL_W  manual channel select
- auto_mode  in  1  1 = auto-scroll, sel ignored
- freeze  in  1  1 = hold displayed value and scroll position
- in_addr  in  ADDR_W  RAM probe address switches
- RAM_addr  out  ADDR_W  = in_addr, combinational
- chose_out  out  DATA_W  registered display word
- disp_idx  out  SEL_W  channel currently driving chose_out
- cnt_ovf  out  NUM_CNT  sticky per-counter saturation flag

## Operation
- Channel map: 0 SyscallOut, 1 PC, 2+i counter i (zero-extended CNT_W→DATA_W), NUM_CH-1 Mdata.
- Counter i: if reset or clr_cnt → 0 and cnt_ovf[i] → 0; else if ev[i] && !halt: if value == 2^CNT_W−1, hold and set cnt_ovf[i]; else +1. Clear beats a simultaneous event. No wrap ever.
- Manual (auto_mode=0): disp_idx ← sel, or ← 0 if sel ≥ NUM_CH.
- Auto (auto_mode=1): scroll timer counts 0..SCROLL_DIV−1; on terminal count disp_idx ← (disp_idx+1) mod NUM_CH, timer → 0. On 0→1 transition of auto_mode, timer → 0, disp_idx retained. Timer held at 0 in manual mode.
- freeze=1: chose_out, disp_idx and scroll timer hold; counters keep counting. On release, normal update resumes next edge.
- chose_out ← channel[disp_idx-next] each unfrozen cycle.

## Timing
- Reset values: chose_out 0, disp_idx 0, all counters 0, cnt_ovf 0, scroll timer 0.
- Latency: sel/source change → chose_out one cycle; ev pulse → counter visible on chose_out two cycles later (counter edge, then display register edge).
- Auto step: disp_idx advances exactly every SCROLL_DIV cycles; wrap NUM_CH−1→0.
- Reset mid-scroll or mid-freeze: everything returns to reset values on that edge regardless of freeze.
- RAM_addr zero latency; Mdata assumed valid same cycle, captured at next edge.

## Structure
- Package perf_display_pkg: channel index constants (CH_SYSCALL=0, CH_PC=1, CH_CNT_BASE=2), function computing NUM_CH/SEL_W.
- Sub-module perf_counter (CNT_W parameter; clk, reset, clr, inc → value, ovf), generated NUM_CNT times.
- Top holds scroll timer, disp_idx register and output mux/register.

## Test plan
- Reset with all inputs nonzero → chose_out=0, disp_idx=0, cnt_ovf=0 on first edge after reset; stays 0 for counters.
- CNT_W=4, ev[0] high 20 cycles, sel=2 → counter saturates at 15, cnt_ovf[0]=1 from 16th event on, chose_out=0x0000000F; then clr_cnt with ev[0]=1 → 0, ovf=0.
- halt=1 with ev all high 10 cycles → all counters unchanged.
- sel=1, PC=0x00400010 → chose_out=0x00400010 one cycle later; sel=7 (NUM_CNT=4, NUM_CH=7, out of range) → SyscallOut shown, disp_idx=0.
- SCROLL_DIV=3, auto_mode=1 from idx 5 → idx 6 after 3 cycles, 0 after 6; freeze for 5 cycles mid-step → idx and chose_out frozen, step resumes with remaining timer count.
- in_addr=0xABC → RAM_addr=0xABC same cycle; sel=NUM_CH−1, Mdata=0xDEADBEEF → chose_out=0xDEADBEEF next edge.
